ram2_arbiter: RTL and testbench

//  Shares the single external RAM2 SRAM between three requesters: boot copy engine (flash->RAM),
//  CPU data port (MEM stage) and CPU instruction fetch. Sequences every SRAM access itself
//  (en/oe/we timing, data-bus drive). Sits between mem_bridge/boot logic and the ram2* pins.

---
 rtl/ram2_arbiter_pkg.sv | 28 ++
 rtl/ram2_arb_pick.sv | 52 +++++
 rtl/ram2_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ram2_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram2_arbiter_pkg.sv
// Shared encodings for the RAM2 arbiter: FSM states, requester IDs and
// the active-low SRAM control levels.
package ram2_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_STROBE = 2'd2,
    ARB_HOLD   = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    ARB_BOOT = 2'd0,
    ARB_DATA = 2'd1,
    ARB_INST = 2'd2,
    ARB_NONE = 2'd3
  } arb_id_t;

  // SRAM control pins are active low.
  localparam logic RAM_ENABLE  = 1'b0;
  localparam logic RAM_DISABLE = 1'b1;

  // Map an "asserted" flag onto the pin level.
  function automatic logic ram_level(input logic active);
    return active ? RAM_ENABLE : RAM_DISABLE;
  endfunction

endpackage

// File: rtl/ram2_arb_pick.sv
// Winner selection for the RAM2 arbiter: fixed priority boot > data > inst,
// with an instruction anti-starvation guard counting data wins over inst.
module ram2_arb_pick
  import ram2_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    boot_req,
  input  logic    data_req,
  input  logic    inst_req,
  input  logic    grant,
  output arb_id_t winner
);

  localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [CNT_W-1:0] starve_q;
  logic             starved;

  assign starved = (starve_q == CNT_W'(STARVE_LIMIT));

  // Combinational priority select; inst jumps ahead of data once starved.
  always_comb begin
    winner = ARB_NONE;
    if (boot_req) begin
      winner = ARB_BOOT;
    end else if (starved && inst_req) begin
      winner = ARB_INST;
    end else if (data_req) begin
      winner = ARB_DATA;
    end else if (inst_req) begin
      winner = ARB_INST;
    end
  end

  // Starve counter: counts data grants that beat a waiting inst request,
  // saturating at the limit; an inst grant clears it, boot grants leave it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (grant) begin
      if (winner == ARB_INST) begin
        starve_q <= '0;
      end else if ((winner == ARB_DATA) && inst_req && !starved) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram2_arbiter.sv
// RAM2 arbiter: shares the external SRAM between boot copy, CPU data and
// CPU instruction fetch, and sequences every access on the ram2 pins
// (IDLE -> SETUP -> STROBE x WAIT_CYCLES -> HOLD -> IDLE).
module ram2_arbiter
  import ram2_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16,
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_req_i,
  input  logic              boot_we_i,
  input  logic [ADDR_W-1:0] boot_addr_i,
  input  logic [DATA_W-1:0] boot_wdata_i,
  output logic              boot_ack_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_ack_o,
  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic              inst_ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic              ram_en_n_o,
  output logic              ram_oe_n_o,
  output logic              ram_we_n_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_data_oe_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  localparam int WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  arb_state_t        state_q, state_d;
  logic [WCNT_W-1:0] wait_q, wait_d;
  logic              wait_last;
  arb_id_t           winner;
  arb_id_t           owner_q;
  logic              grant;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Requests are only looked at while idle; a grant launches an access.
  assign grant     = (state_q == ARB_IDLE) && (winner != ARB_NONE);
  assign wait_last = (wait_q == WCNT_W'(WAIT_CYCLES - 1));

  ram2_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk      (clk),
    .rst      (rst),
    .boot_req (boot_req_i),
    .data_req (data_req_i),
    .inst_req (inst_req_i),
    .grant    (grant),
    .winner   (winner)
  );

  // Route the winning requester's command toward the access registers.
  always_comb begin
    sel_we    = we_q;
    sel_addr  = addr_q;
    sel_wdata = wdata_q;
    case (winner)
      ARB_BOOT: begin
        sel_we    = boot_we_i;
        sel_addr  = boot_addr_i;
        sel_wdata = boot_wdata_i;
      end
      ARB_DATA: begin
        sel_we    = data_we_i;
        sel_addr  = data_addr_i;
        sel_wdata = data_wdata_i;
      end
      ARB_INST: begin
        sel_we   = 1'b0;
        sel_addr = inst_addr_i;
      end
      default: ;
    endcase
  end

  // Next-state logic and pin timing decoded from the current state.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    ram_en_n_o    = RAM_DISABLE;
    ram_oe_n_o    = RAM_DISABLE;
    ram_we_n_o    = RAM_DISABLE;
    ram_data_oe_o = 1'b0;
    boot_ack_o    = 1'b0;
    data_ack_o    = 1'b0;
    inst_ack_o    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        wait_d = '0;
        if (grant) begin
          state_d = ARB_SETUP;
        end
      end
      ARB_SETUP: begin
        ram_en_n_o    = RAM_ENABLE;
        ram_oe_n_o    = ram_level(!we_q);
        ram_data_oe_o = we_q;
        wait_d        = '0;
        state_d       = ARB_STROBE;
      end
      ARB_STROBE: begin
        ram_en_n_o    = RAM_ENABLE;
        ram_oe_n_o    = ram_level(!we_q);
        ram_we_n_o    = ram_level(we_q);
        ram_data_oe_o = we_q;
        if (wait_last) begin
          state_d = ARB_HOLD;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ARB_HOLD: begin
        // Write data and address stay on the pins for hold time.
        ram_en_n_o    = RAM_ENABLE;
        ram_data_oe_o = we_q;
        boot_ack_o    = (owner_q == ARB_BOOT);
        data_ack_o    = (owner_q == ARB_DATA);
        inst_ack_o    = (owner_q == ARB_INST);
        state_d       = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // FSM state, access command capture and read-data latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      wait_q  <= '0;
      owner_q <= ARB_NONE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (grant) begin
        owner_q <= winner;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
      end
      if ((state_q == ARB_STROBE) && wait_last && !we_q) begin
        rdata_q <= ram_data_i;
      end
    end
  end

  // Write data is only meaningful while data_oe is up, so it needs no reset.
  always_ff @(posedge clk) begin
    if (grant) begin
      wdata_q <= sel_wdata;
    end
  end

  assign rdata_o    = rdata_q;
  assign busy_o     = (state_q != ARB_IDLE);
  assign ram_addr_o = addr_q;
  assign ram_data_o = wdata_q;

endmodule

// File: tb/tb_ram2_arbiter.sv
// Testbench for ram2_arbiter: table of single accesses against an SRAM
// model, then reset abort, simultaneous requests, starvation guard and a
// 256-word boot copy.
module tb_ram2_arbiter;

  localparam int ADDR_W       = 18;
  localparam int DATA_W       = 16;
  localparam int WAIT_CYCLES  = 1;
  localparam int STARVE_LIMIT = 4;

  logic              clk;
  logic              rst;
  logic              boot_req, boot_we, data_req, data_we, inst_req;
  logic [ADDR_W-1:0] boot_addr, data_addr, inst_addr;
  logic [DATA_W-1:0] boot_wdata, data_wdata;
  logic              boot_ack, data_ack, inst_ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              ram_en_n, ram_oe_n, ram_we_n, ram_data_oe;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_o, ram_data_i;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  ram2_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .WAIT_CYCLES(WAIT_CYCLES), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .boot_req_i(boot_req), .boot_we_i(boot_we), .boot_addr_i(boot_addr),
    .boot_wdata_i(boot_wdata), .boot_ack_o(boot_ack),
    .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_ack_o(data_ack),
    .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_ack_o(inst_ack),
    .rdata_o(rdata), .busy_o(busy),
    .ram_en_n_o(ram_en_n), .ram_oe_n_o(ram_oe_n), .ram_we_n_o(ram_we_n),
    .ram_addr_o(ram_addr), .ram_data_o(ram_data_o),
    .ram_data_oe_o(ram_data_oe), .ram_data_i(ram_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model (4K words is enough for the addresses used) with backdoor load.
  logic [15:0] mem [0:4095];
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = '0;
  logic [15:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (!ram_en_n && !ram_we_n && ram_data_oe) mem[ram_addr[11:0]] <= ram_data_o;
  end

  assign ram_data_i = (!ram_en_n && !ram_oe_n) ? mem[ram_addr[11:0]] : 16'hDEAD;

  // Pin-protocol monitor: bus contention, write without drive, multiple acks.
  always @(negedge clk) begin
    if (!rst) begin
      if (!ram_we_n && (ram_en_n || !ram_data_oe)) viol <= viol + 1;
      if (!ram_oe_n && ram_data_oe) viol <= viol + 1;
      if ((int'(boot_ack) + int'(data_ack) + int'(inst_ack)) > 1) viol <= viol + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    case (id)
      0: begin boot_req = v; boot_we = we; boot_addr = a; boot_wdata = d; end
      1: begin data_req = v; data_we = we; data_addr = a; data_wdata = d; end
      default: begin inst_req = v; inst_addr = a; end
    endcase
  endtask

  function automatic logic ack_of(input int id);
    case (id)
      0: return boot_ack;
      1: return data_ack;
      default: return inst_ack;
    endcase
  endfunction

  function automatic logic [15:0] copy_word(input int i);
    logic [15:0] v;
    v = 16'(i * 257);
    return v ^ 16'h3C00;
  endfunction

  typedef struct {
    int          id;
    logic        we;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_lat;
    int          exp_oe;
    int          exp_we;
    int          exp_doe;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, oe_cnt, we_cnt, doe_cnt, other_ack, k, cyc, mism, multi;
    logic got;
    int          ord [3];
    int          at   [3];
    logic [15:0] rd  [3];
    int          seq [20];
    int          seq_cyc [20];

    //            id we addr     wdata    rdata    lat oe we doe
    vecs[0] = '{2, 1'b0, 18'h040, 16'h0000, 16'h1234, 3, 2, 0, 0};
    vecs[1] = '{1, 1'b1, 18'h100, 16'hBEEF, 16'h1234, 3, 0, 1, 3};
    vecs[2] = '{1, 1'b0, 18'h100, 16'h0000, 16'hBEEF, 3, 2, 0, 0};
    vecs[3] = '{0, 1'b1, 18'h200, 16'h5A5A, 16'hBEEF, 3, 0, 1, 3};
    vecs[4] = '{0, 1'b0, 18'h200, 16'h0000, 16'h5A5A, 3, 2, 0, 0};
    vecs[5] = '{2, 1'b0, 18'h100, 16'h0000, 16'hBEEF, 3, 2, 0, 0};
    vecs[6] = '{1, 1'b1, 18'h040, 16'h0001, 16'hBEEF, 3, 0, 1, 3};
    vecs[7] = '{2, 1'b0, 18'h040, 16'h0000, 16'h0001, 3, 2, 0, 0};

    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    set_req(2, 1'b0, 1'b0, '0, '0);

    // Clear the model region and preload word 0x0040.
    for (int i = 0; i < 4096; i++) begin
      bd_we = 1'b1; bd_addr = 12'(i); bd_data = (i == 'h40) ? 16'h1234 : 16'h0000;
      step();
    end
    bd_we = 1'b0;

    // Reset state
    check("rst_en_n", 32'(ram_en_n), 1);
    check("rst_oe_n", 32'(ram_oe_n), 1);
    check("rst_we_n", 32'(ram_we_n), 1);
    check("rst_data_oe", 32'(ram_data_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_acks", {29'd0, boot_ack, data_ack, inst_ack}, 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_addr", 32'(ram_addr), 0);
    rst = 1'b0;
    step();

    // Table of single accesses
    for (int i = 0; i < 8; i++) begin
      set_req(vecs[i].id, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      lat = 0; oe_cnt = 0; we_cnt = 0; doe_cnt = 0; other_ack = 0; got = 1'b0;
      while (!got && lat < 20) begin
        step();
        lat++;
        if (!ram_oe_n) oe_cnt++;
        if (!ram_we_n) we_cnt++;
        if (ram_data_oe) doe_cnt++;
        for (int j = 0; j < 3; j++) if (j != vecs[i].id && ack_of(j)) other_ack++;
        if (ack_of(vecs[i].id)) got = 1'b1;
      end
      check($sformatf("vec%0d_ack", i), 32'(got), 1);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_oe_cycles", i), 32'(oe_cnt), 32'(vecs[i].exp_oe));
      check($sformatf("vec%0d_we_cycles", i), 32'(we_cnt), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d_doe_cycles", i), 32'(doe_cnt), 32'(vecs[i].exp_doe));
      check($sformatf("vec%0d_other_ack", i), 32'(other_ack), 0);
      set_req(vecs[i].id, 1'b0, 1'b0, '0, '0);
      step();
      check($sformatf("vec%0d_idle_en_n", i), 32'(ram_en_n), 1);
      check($sformatf("vec%0d_idle_doe", i), 32'(ram_data_oe), 0);
    end

    // Reset in the middle of a write strobe
    set_req(1, 1'b1, 1'b1, 18'h300, 16'h7777);
    step();
    step();
    check("abort_strobe_we_n", 32'(ram_we_n), 0);
    rst = 1'b1;
    set_req(1, 1'b0, 1'b0, '0, '0);
    step();
    check("abort_we_n", 32'(ram_we_n), 1);
    check("abort_en_n", 32'(ram_en_n), 1);
    check("abort_doe", 32'(ram_data_oe), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_rdata", 32'(rdata), 0);
    check("abort_addr", 32'(ram_addr), 0);
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (boot_ack || data_ack || inst_ack) k++;
    end
    check("abort_no_ack", 32'(k), 0);

    // Simultaneous boot, data, inst reads
    set_req(0, 1'b1, 1'b0, 18'h200, '0);
    set_req(1, 1'b1, 1'b0, 18'h100, '0);
    set_req(2, 1'b1, 1'b0, 18'h040, '0);
    k = 0; cyc = 0; multi = 0;
    while (k < 3 && cyc < 40) begin
      step();
      cyc++;
      if ((int'(boot_ack) + int'(data_ack) + int'(inst_ack)) > 1) multi++;
      for (int j = 0; j < 3; j++) begin
        if (ack_of(j) && k < 3) begin
          ord[k] = j; at[k] = cyc; rd[k] = rdata; k++;
          set_req(j, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    check("simul_acks", 32'(k), 3);
    check("simul_multi", 32'(multi), 0);
    if (k == 3) begin
      check("simul_first", 32'(ord[0]), 0);
      check("simul_second", 32'(ord[1]), 1);
      check("simul_third", 32'(ord[2]), 2);
      check("simul_boot_cyc", 32'(at[0]), 3);
      check("simul_data_cyc", 32'(at[1]), 7);
      check("simul_inst_cyc", 32'(at[2]), 11);
      check("simul_boot_rdata", 32'(rd[0]), 32'h5A5A);
      check("simul_data_rdata", 32'(rd[1]), 32'hBEEF);
      check("simul_inst_rdata", 32'(rd[2]), 32'h0001);
    end
    step();

    // Data and inst held continuously: starvation guard
    set_req(1, 1'b1, 1'b0, 18'h100, '0);
    set_req(2, 1'b1, 1'b0, 18'h040, '0);
    k = 0; cyc = 0;
    while (k < 20 && cyc < 120) begin
      step();
      cyc++;
      if (data_ack || inst_ack) begin
        seq[k] = data_ack ? 1 : 2;
        seq_cyc[k] = cyc;
        k++;
        if (k == 20) begin
          set_req(1, 1'b0, 1'b0, '0, '0);
          set_req(2, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    check("starve_acks", 32'(k), 20);
    if (k == 20) begin
      for (int i = 0; i < 20; i++)
        check($sformatf("starve_ack%0d_id", i), 32'(seq[i]), (i % 5 == 4) ? 2 : 1);
      check("starve_last_cyc", 32'(seq_cyc[19]), 79);
    end
    step();
    step();

    // Boot copies 256 words with CPU ports idle
    set_req(0, 1'b1, 1'b1, 18'h400, copy_word(0));
    k = 0; cyc = 0;
    while (k < 256 && cyc < 1100) begin
      step();
      cyc++;
      if (boot_ack) begin
        k++;
        if (k < 256) set_req(0, 1'b1, 1'b1, 18'h400 + 18'(k), copy_word(k));
        else set_req(0, 1'b0, 1'b0, '0, '0);
      end
    end
    check("copy_acks", 32'(k), 256);
    check("copy_last_cyc", 32'(cyc), 1023);
    step();
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[12'h400 + 12'(i)] !== copy_word(i)) mism++;
    check("copy_contents", 32'(mism), 0);

    check("protocol_violations", 32'(viol), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
